// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter
//   Shares one iterative square-root core among N requesters. A round-robin
//   grant picks one requester in IDLE. Its radicand is issued to the core with
//   a one-cycle start pulse. The core's result, or a watchdog error if the core
//   never reports valid, is then returned on a backpressured response port
//   tagged with the requester index.
//
//   Ports
//     clk, rst               clock, asynchronous active-high reset
//     req_valid/req_ready    per-requester handshake (req_ready is one-hot)
//     req_rad                packed radicands, requester i at [i*WIDTH +: WIDTH]
//     rsp_valid/rsp_ready    response handshake
//     rsp_id/root/rem/err    registered response payload
//     core_start/core_rad    drive the shared core
//     core_busy              core status (observed only)
//     core_valid/root/rem    core result
//
//   Handshake rule for both ports: a transfer happens on a rising edge where
//   valid and ready are both 1. The response payload stays stable while
//   rsp_valid=1 and rsp_ready=0.
module sqrt_arbiter #(
  parameter int WIDTH   = 8,
  parameter int N       = 4,
  // Core iteration count is WIDTH/2; the watchdog allows four extra cycles.
  parameter int TIMEOUT = WIDTH / 2 + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_rad,
  output logic [N-1:0]         req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [WIDTH-1:0]     rsp_root,
  output logic [WIDTH-1:0]     rsp_rem,
  output logic                 rsp_err,
  output logic                 core_start,
  output logic [WIDTH-1:0]     core_rad,
  input  logic                 core_busy,
  input  logic                 core_valid,
  input  logic [WIDTH-1:0]     core_root,
  input  logic [WIDTH-1:0]     core_rem
);

  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [WIDTH-1:0]   rad_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   root_q;
  logic [WIDTH-1:0]   rem_q;
  logic               err_q;

  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic [WIDTH-1:0]   gnt_rad;
  logic [ID_W:0]      cand;

  // Round-robin search starting at ptr_q. cand has one extra bit, so the
  // wrap past N-1 works for any N, including non-powers of two.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_rad   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(N)) begin
        cand = cand - (ID_W + 1)'(N);
      end
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        gnt_rad = req_rad[i*WIDTH +: WIDTH];
      end
    end
  end

  // Accept strobe: only in IDLE, and held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_found && !rst) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (gnt_found) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (core_valid || cnt_q == CNT_W'(TIMEOUT)) state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      id_q   <= '0;
      rad_q  <= '0;
      cnt_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            rad_q <= gnt_rad;
            id_q  <= gnt_idx;
            ptr_q <= (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        ISSUE: begin
          cnt_q <= '0;
        end
        WAIT: begin
          // A valid that arrives on the timeout cycle still counts as a result.
          if (core_valid) begin
            root_q <= core_root;
            rem_q  <= core_rem;
            err_q  <= 1'b0;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            root_q <= '0;
            rem_q  <= '0;
            err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_root   = root_q;
  assign rsp_rem    = rem_q;
  assign rsp_err    = err_q;
  assign core_start = (state_q == ISSUE);
  assign core_rad   = rad_q;

  // The core must not report a result while it is still iterating.
  a_valid_not_busy: assert property (@(posedge clk) disable iff (rst)
    !(core_valid && core_busy));

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Testbench for sqrt_arbiter. It contains a behavioural square-root core with
// ITER-cycle latency, which can be hung, and a request/response scoreboard.
// Every expected value comes from plain integer square-root arithmetic and
// the round-robin grant rule.
module tb_sqrt_arbiter;

  localparam int WIDTH   = 8;
  localparam int N       = 4;
  localparam int ITER    = WIDTH / 2;
  localparam int TIMEOUT = ITER + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_rad;
  logic [N-1:0]       req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [WIDTH-1:0]   rsp_root, rsp_rem;
  logic               rsp_err;
  logic               core_start;
  logic [WIDTH-1:0]   core_rad;
  logic               core_busy, core_valid;
  logic [WIDTH-1:0]   core_root, core_rem;

  sqrt_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rad(req_rad), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_root(rsp_root), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
    .core_start(core_start), .core_rad(core_rad), .core_busy(core_busy),
    .core_valid(core_valid), .core_root(core_root), .core_rem(core_rem)
  );

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // ---------------- behavioural core ----------------
  logic             core_hang = 1'b0;
  logic [WIDTH-1:0] c_root = '0, c_rem = '0;
  logic             c_valid = 1'b0;
  int               c_cnt = 0;

  always @(posedge clk) begin
    if (core_start) begin
      c_cnt   <= ITER;
      c_valid <= 1'b0;
      c_root  <= WIDTH'(isqrt(int'(core_rad)));
      c_rem   <= WIDTH'(int'(core_rad) - isqrt(int'(core_rad)) * isqrt(int'(core_rad)));
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) c_valid <= 1'b1;
    end
  end

  assign core_busy  = (c_cnt != 0);
  assign core_valid = c_valid & ~core_hang;
  assign core_root  = c_root;
  assign core_rem   = c_rem;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] pend_mem [N][8];
  int               pend_n   [N];
  int               stall_cnt = 0;
  logic             rand_rsp  = 1'b0;

  logic [WIDTH-1:0] exp_id_q[$], exp_root_q[$], exp_rem_q[$], exp_err_q[$];
  int               order_q[$];

  int               m_ptr = 0;
  int               acc_cyc = 0;
  logic             acc_pending = 1'b0;
  int               acc_id = 0;
  logic [WIDTH-1:0] exp_rad = '0;
  logic             saw_start = 1'b0;
  logic             prev_start = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
  logic [1:0]       held_id = '0;
  logic [WIDTH-1:0] held_root = '0, held_rem = '0;
  logic             held_err = 1'b0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),  0);
    check({tag, "_rsp_valid"},  32'(rsp_valid),  0);
    check({tag, "_rsp_id"},     32'(rsp_id),     0);
    check({tag, "_rsp_root"},   32'(rsp_root),   0);
    check({tag, "_rsp_rem"},    32'(rsp_rem),    0);
    check({tag, "_rsp_err"},    32'(rsp_err),    0);
    check({tag, "_core_start"}, 32'(core_start), 0);
    check({tag, "_core_rad"},   32'(core_rad),   0);
  endtask

  // Round-robin reference: first valid index scanning from ptr with wrap.
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic push_req(input int id, input int rad);
    if (pend_n[id] < 8) begin
      pend_mem[id][pend_n[id]] = WIDTH'(rad);
      pend_n[id]++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (pend_n[i] > 0);
      req_rad[i*WIDTH +: WIDTH] = (pend_n[i] > 0) ? pend_mem[i][0] : WIDTH'($urandom);
    end
    if (stall_cnt > 0 && rsp_valid) begin
      rsp_ready = 1'b0;
      stall_cnt--;
    end else begin
      rsp_ready = rand_rsp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  // Observes the DUT at the falling edge, mid-cycle.
  task automatic monitor();
    int g;
    int r;
    if (rst) begin
      prev_start = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0;
      return;
    end
    if (rsp_valid) begin
      check("ready_in_resp", 32'(req_ready), 0);
      check("start_in_resp", 32'(core_start), 0);
    end else if (req_ready != '0) begin
      g = model_grant(req_valid, m_ptr);
      if (g < 0) begin
        check("spurious_ready", 32'(req_ready), 0);
      end else begin
        check("grant", 32'(req_ready), 32'(1) << g);
        exp_rad = pend_mem[g][0];
        r = isqrt(int'(exp_rad));
        exp_id_q.push_back(WIDTH'(g));
        exp_root_q.push_back(core_hang ? '0 : WIDTH'(r));
        exp_rem_q.push_back(core_hang ? '0 : WIDTH'(int'(exp_rad) - r * r));
        exp_err_q.push_back(core_hang ? WIDTH'(1) : WIDTH'(0));
        acc_cyc     = cyc + 1;
        m_ptr       = (g + 1) % N;
        acc_pending = 1'b1;
        acc_id      = g;
      end
    end
    if (core_start) begin
      saw_start = 1'b1;
      check("start_cycle", 32'(cyc), 32'(acc_cyc));
      check("core_rad", 32'(core_rad), 32'(exp_rad));
    end
    if (prev_start) check("start_pulse", 32'(core_start), 0);
    if (prev_rv && prev_rr) check("rsp_drop", 32'(rsp_valid), 0);
    if (rsp_valid && !prev_rv && exp_err_q.size() > 0) begin
      check("latency", 32'(cyc - acc_cyc), (exp_err_q[0] != '0) ? TIMEOUT + 2 : ITER + 2);
    end
    if (rsp_valid && prev_rv && !prev_rr) begin
      check("hold_id",   32'(rsp_id),   32'(held_id));
      check("hold_root", 32'(rsp_root), 32'(held_root));
      check("hold_rem",  32'(rsp_rem),  32'(held_rem));
      check("hold_err",  32'(rsp_err),  32'(held_err));
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_id_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 0);
      end else begin
        check("rsp_id",   32'(rsp_id),   32'(exp_id_q.pop_front()));
        check("rsp_root", 32'(rsp_root), 32'(exp_root_q.pop_front()));
        check("rsp_rem",  32'(rsp_rem),  32'(exp_rem_q.pop_front()));
        check("rsp_err",  32'(rsp_err),  32'(exp_err_q.pop_front()));
      end
      order_q.push_back(int'(rsp_id));
    end
    prev_start = core_start;
    prev_rv    = rsp_valid;
    prev_rr    = rsp_ready;
    held_id    = rsp_id;
    held_root  = rsp_root;
    held_rem   = rsp_rem;
    held_err   = rsp_err;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    if (acc_pending) begin
      for (int j = 0; j < 7; j++) pend_mem[acc_id][j] = pend_mem[acc_id][j+1];
      pend_n[acc_id]--;
      acc_pending = 1'b0;
    end
    #1 drive();
  endtask

  function automatic logic all_idle();
    for (int i = 0; i < N; i++) if (pend_n[i] != 0) return 1'b0;
    return (exp_id_q.size() == 0) && !acc_pending && !rsp_valid;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (!all_idle()) begin
      tick();
      t++;
      if (t > budget) begin
        check({tag, "_drain_timeout"}, 32'(t), 32'(budget));
        break;
      end
    end
  endtask

  task automatic check_order(input string tag, input int exp_ids[]);
    check({tag, "_count"}, 32'(order_q.size()), 32'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < order_q.size(); i++) begin
      check({tag, "_order"}, 32'(order_q[i]), 32'(exp_ids[i]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    for (int i = 0; i < N; i++) pend_n[i] = 0;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_rad = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    push_req(2, 144);
    drive();
    #1 check("ready_in_rst", 32'(req_ready), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Single request, requester 2, 144 -> 12 r 0.
    order_q.delete();
    wait_done("single", 60);
    check_order("single", '{2});

    // Remainder cases on requester 3; leaves ptr at 0.
    push_req(3, 255); push_req(3, 0); push_req(3, 1);
    wait_done("rem", 100);

    // All four requesters valid continuously.
    order_q.delete();
    push_req(0, 4); push_req(0, 4); push_req(1, 9); push_req(2, 16); push_req(3, 25);
    wait_done("rr4", 200);
    check_order("rr4", '{0, 1, 2, 3, 0});

    // Only requesters 1 and 3, ptr now 1.
    order_q.delete();
    push_req(1, 36); push_req(1, 49); push_req(3, 64);
    wait_done("rr2", 150);
    check_order("rr2", '{1, 3, 1});

    // Backpressure: five stalled RESP cycles while another request waits.
    stall_cnt = 5;
    push_req(0, 200); push_req(2, 99);
    wait_done("bp", 150);
    check("bp_stall_used", 32'(stall_cnt), 0);

    // Reset three cycles into WAIT.
    push_req(1, 200);
    saw_start = 1'b0;
    t = 0;
    while (!saw_start && t < 50) begin tick(); t++; end
    check("mid_start_seen", 32'(saw_start), 1);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 check_outputs_zero("mid_rst");
    exp_id_q.delete(); exp_root_q.delete(); exp_rem_q.delete(); exp_err_q.delete();
    acc_pending = 1'b0;
    m_ptr = 0;
    repeat (2) tick();
    check_outputs_zero("mid_rst_hold");
    rst = 1'b0;
    order_q.delete();
    push_req(2, 49);
    wait_done("after_rst", 60);
    check_order("after_rst", '{2});

    // Watchdog with a hung core, then recovery.
    core_hang = 1'b1;
    push_req(1, 100);
    wait_done("wdog", 80);
    core_hang = 1'b0;
    push_req(1, 81);
    wait_done("recover", 60);

    // Randomized traffic with random response backpressure.
    rand_rsp = 1'b1;
    for (int j = 0; j < 20; j++) begin
      int nreq;
      nreq = $urandom_range(1, 3);
      for (int k = 0; k < nreq; k++) push_req($urandom_range(0, N - 1), $urandom_range(0, 255));
      t = $urandom_range(0, 15);
      repeat (t) tick();
    end
    wait_done("random", 2000);
    rand_rsp = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
